// File: rtl/parking_fsm.sv
// ---------------------------------------------------------------------------
// parking_fsm
//
// Tracks occupancy of a four-slot car park as a registered bitmap. Each
// cycle the optional exit is applied first, then an entering car takes the
// lowest-index free slot that remains. A one-cycle door pulse follows every
// cycle in which an entry or exit was accepted.
//
// Ports:
//   clk            sole clock, all state changes on the rising edge
//   reset          synchronous active-high reset, wins over both sensors
//   entry_sensor   a car requests entry this cycle
//   exit_sensor    a car leaves this cycle
//   exit_location  slot index being vacated (used only with exit_sensor)
//   door_open      registered; high the cycle after an accepted entry/exit
//   full_light     high when all four slots are occupied
//   current_state  registered occupancy bitmap, bit i set = slot i taken
//   capacity       number of occupied slots (0..4)
//   best_slot      lowest-index free slot, 0 when the lot is full
//
// Build option:
//   PARKING_EXIT_CHECK_EN  when defined, an exit addressing a slot that is
//                          already free is ignored (no change, no door pulse)
// ---------------------------------------------------------------------------
module parking_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic [1:0] exit_location,
  output logic       door_open,
  output logic       full_light,
  output logic [3:0] current_state,
  output logic [2:0] capacity,
  output logic [1:0] best_slot
);

  logic [3:0] state_q, state_d;
  logic       door_q, door_d;

  logic       exit_accept;
  logic       entry_accept;
  logic [3:0] cleared;
  logic [3:0] entry_onehot;

  // Lowest-index zero bit of a bitmap; returns 0 when there is none.
  function automatic logic [1:0] lowest_free(input logic [3:0] map);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!map[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Next-state: apply the exit first so a car leaving a full lot frees a
  // slot that a simultaneous entry can then reuse.
  always_comb begin
    state_d      = state_q;
    door_d       = 1'b0;
    cleared      = state_q;
    entry_onehot = 4'b0000;

`ifdef PARKING_EXIT_CHECK_EN
    exit_accept = exit_sensor && state_q[exit_location];
`else
    exit_accept = exit_sensor;
`endif

    if (exit_accept) cleared[exit_location] = 1'b0;

    entry_accept = entry_sensor && (cleared != 4'b1111);
    if (entry_accept) entry_onehot[lowest_free(cleared)] = 1'b1;

    state_d = cleared | entry_onehot;
    door_d  = exit_accept || entry_accept;
  end

  // Reset discards any sensor activity in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 4'b0000;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      door_q  <= door_d;
    end
  end

  // Status outputs are decoded straight from the registered bitmap so they
  // line up with current_state in the same cycle.
  always_comb begin
    capacity = 3'(state_q[0]) + 3'(state_q[1]) + 3'(state_q[2]) + 3'(state_q[3]);
  end

  assign current_state = state_q;
  assign door_open     = door_q;
  assign full_light    = &state_q;
  assign best_slot     = lowest_free(state_q);

endmodule

// File: tb/tb_parking_fsm.sv
// ---------------------------------------------------------------------------
// tb_parking_fsm
//
// Directed vectors for parking_fsm. Each vector is driven before a rising
// edge and the registered outputs are compared one time unit after it.
// ---------------------------------------------------------------------------
module tb_parking_fsm;

  logic       clk;
  logic       reset;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] exit_location;
  logic       door_open;
  logic       full_light;
  logic [3:0] current_state;
  logic [2:0] capacity;
  logic [1:0] best_slot;

  int compared;
  int mismatched;

  parking_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .entry_sensor  (entry_sensor),
    .exit_sensor   (exit_sensor),
    .exit_location (exit_location),
    .door_open     (door_open),
    .full_light    (full_light),
    .current_state (current_state),
    .capacity      (capacity),
    .best_slot     (best_slot)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then settle past the edge.
  task automatic applyStimulus(input logic rst, input logic ent, input logic ext,
                               input logic [1:0] loc);
    reset         = rst;
    entry_sensor  = ent;
    exit_sensor   = ext;
    exit_location = loc;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    entry_sensor  = 1'b0;
    exit_sensor   = 1'b0;
    exit_location = 2'd0;
  endtask

  // Check every output against hand-computed values for one step.
  task automatic checkAll(input string tag, input int st, input int cap,
                          input int best, input int door, input int full);
    checkOutput({tag, ".state"}, int'(current_state), st);
    checkOutput({tag, ".cap"},   int'(capacity),      cap);
    checkOutput({tag, ".best"},  int'(best_slot),     best);
    checkOutput({tag, ".door"},  int'(door_open),     door);
    checkOutput({tag, ".full"},  int'(full_light),    full);
  endtask

  int exp_door_free_exit;

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b0;
    entry_sensor  = 1'b0;
    exit_sensor   = 1'b0;
    exit_location = 2'd0;
`ifdef PARKING_EXIT_CHECK_EN
    exp_door_free_exit = 0;
`else
    exp_door_free_exit = 1;
`endif

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    checkAll("reset", 0, 0, 0, 0, 0);

    // Fill the lot one car per cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("fill1", 4'b0001, 1, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("fill2", 4'b0011, 2, 2, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("fill3", 4'b0111, 3, 3, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("fill4", 4'b1111, 4, 0, 1, 1);

    // Entry rejected on a full lot
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("fullrej", 4'b1111, 4, 0, 0, 1);

    // Exit slot 2 from full lot
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2);
    checkAll("exit2", 4'b1011, 3, 2, 1, 0);

    // Entry refills the hole at slot 2
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("refill2", 4'b1111, 4, 0, 1, 1);

    // Simultaneous entry and exit on a full lot
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
    checkAll("swap1", 4'b1111, 4, 0, 1, 1);

    // Idle cycle holds state and drops the door
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
    checkAll("idle", 4'b1111, 4, 0, 0, 1);

    // Reset mid-operation, then exit of a free slot
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    checkAll("reset2", 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("one", 4'b0001, 1, 1, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3);
    checkAll("freeexit", 4'b0001, 1, 1, exp_door_free_exit, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
    checkAll("exit0", 4'b0000, 0, 0, 1, 0);

    // Build 0111, open a hole in the middle, refill it
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("three", 4'b0111, 3, 3, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1);
    checkAll("exit1", 4'b0101, 2, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("refill1", 4'b0111, 3, 3, 1, 0);

    // Reset wins over a simultaneous entry
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    checkAll("rstprio", 0, 0, 0, 0, 0);

    // First cycle after reset behaves like an empty lot
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    checkAll("postrst", 4'b0001, 1, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
